// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI master arbiter: FSM states and the per-requester
// configuration record (freq, chip-select address, packet size).
package spi_arb_pkg;

    localparam int unsigned NBITS      = 34;
    localparam int unsigned NCS        = 1;
    localparam int unsigned LOG_BITS_N = $clog2(NBITS) + 1;
    localparam int unsigned LOG_CS_N   = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int unsigned FREQ_W     = 3;
    localparam int unsigned CFG_W      = FREQ_W + LOG_CS_N + LOG_BITS_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0]     freq;
        logic [LOG_CS_N-1:0]   cs_addr;
        logic [LOG_BITS_N-1:0] packet_size;
    } spi_cfg_t;

    localparam spi_cfg_t CFG_RESET = '{
        freq:        '0,
        cs_addr:     '0,
        packet_size: LOG_BITS_N'(NBITS)
    };

endpackage

// File: rtl/spi_master_arbiter_rr.sv
// Combinational round-robin select: first requester at or above rr_ptr
// (with wrap) that has req_val high.
module spi_rr_arbiter #(
    parameter int unsigned nreq = 4
) (
    input  logic [nreq-1:0]         req_val,
    input  logic [$clog2(nreq)-1:0] rr_ptr,
    output logic [nreq-1:0]         gnt_onehot,
    output logic [$clog2(nreq)-1:0] gnt_idx,
    output logic                    gnt_any
);

    localparam int unsigned logReqN = $clog2(nreq);

    logic [logReqN-1:0] cand_c;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        cand_c     = '0;
        for (int unsigned off = 0; off < nreq; off++) begin
            cand_c = logReqN'((32'(rr_ptr) + off) % nreq);
            if (!gnt_any && req_val[cand_c]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_c;
            end
        end
        if (gnt_any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among nreq requesters: round-robin grant, per-port
// config storage, and an IDLE/ISSUE/WAIT sequencer that routes the response back.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned nreq = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [nreq-1:0]            req_val,
    output logic [nreq-1:0]            req_rdy,
    input  logic [nreq*NBITS-1:0]      req_msg,

    output logic [nreq-1:0]            resp_val,
    input  logic [nreq-1:0]            resp_rdy,
    output logic [NBITS-1:0]           resp_msg,

    input  logic                       cfg_val,
    output logic                       cfg_rdy,
    input  logic [$clog2(nreq)-1:0]    cfg_addr,
    input  logic [CFG_W-1:0]           cfg_msg,

    output logic                       spi_recv_val,
    input  logic                       spi_recv_rdy,
    output logic [NBITS-1:0]           spi_recv_msg,

    input  logic                       spi_send_val,
    output logic                       spi_send_rdy,
    input  logic [NBITS-1:0]           spi_send_msg,

    output logic                       spi_pkt_val,
    input  logic                       spi_pkt_rdy,
    output logic [LOG_BITS_N-1:0]      spi_pkt_msg,

    output logic                       spi_cs_val,
    input  logic                       spi_cs_rdy,
    output logic [LOG_CS_N-1:0]        spi_cs_msg,

    output logic                       spi_freq_val,
    input  logic                       spi_freq_rdy,
    output logic [FREQ_W-1:0]          spi_freq_msg
);

    localparam int unsigned nbits   = NBITS;
    localparam int unsigned logReqN = $clog2(nreq);

    arb_state_e         state_q, state_d;
    logic [logReqN-1:0] rr_ptr_q, rr_ptr_d;
    logic [logReqN-1:0] gnt_q, gnt_d;
    logic [nbits-1:0]   msg_q, msg_d;
    spi_cfg_t           issue_cfg_q, issue_cfg_d;
    spi_cfg_t           cfg_q [nreq];
    spi_cfg_t           cfg_d [nreq];

    logic [nbits-1:0]   req_msg_arr [nreq];
    logic [nreq-1:0]    arb_gnt_c;
    logic [logReqN-1:0] arb_idx_c;
    logic               arb_any_c;

    // The master's pkt/cs/freq ports accept in lock-step with its request port.
    logic               unused_rdy;
    assign unused_rdy = ^{spi_pkt_rdy, spi_cs_rdy, spi_freq_rdy};

    for (genvar i = 0; i < int'(nreq); i++) begin : g_unpack
        assign req_msg_arr[i] = req_msg[i*nbits +: nbits];
    end

    spi_rr_arbiter #(.nreq(nreq)) u_rr_arbiter (
        .req_val    (req_val),
        .rr_ptr     (rr_ptr_q),
        .gnt_onehot (arb_gnt_c),
        .gnt_idx    (arb_idx_c),
        .gnt_any    (arb_any_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            msg_q       <= '0;
            issue_cfg_q <= CFG_RESET;
            for (int i = 0; i < int'(nreq); i++) begin
                cfg_q[i] <= CFG_RESET;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            msg_q       <= msg_d;
            issue_cfg_q <= issue_cfg_d;
            cfg_q       <= cfg_d;
        end
    end

    // Grant latches cfg_q (pre-write), so a same-cycle config write hits the next request.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        msg_d       = msg_q;
        issue_cfg_d = issue_cfg_q;
        cfg_d       = cfg_q;

        if (cfg_val && (int'(cfg_addr) < int'(nreq))) begin
            cfg_d[cfg_addr] = spi_cfg_t'(cfg_msg);
        end

        unique case (state_q)
            IDLE: begin
                if (arb_any_c) begin
                    state_d     = ISSUE;
                    gnt_d       = arb_idx_c;
                    msg_d       = req_msg_arr[arb_idx_c];
                    issue_cfg_d = cfg_q[arb_idx_c];
                end
            end
            ISSUE: begin
                if (spi_recv_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (spi_send_val && resp_rdy[gnt_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == logReqN'(nreq - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state; req_rdy is held low while reset is applied.
    always_comb begin
        req_rdy      = '0;
        resp_val     = '0;
        resp_msg     = '0;
        spi_send_rdy = 1'b0;
        spi_recv_val = 1'b0;
        spi_recv_msg = '0;
        spi_pkt_val  = 1'b0;
        spi_pkt_msg  = '0;
        spi_cs_val   = 1'b0;
        spi_cs_msg   = '0;
        spi_freq_val = 1'b0;
        spi_freq_msg = '0;

        unique case (state_q)
            IDLE: begin
                req_rdy = reset ? '0 : arb_gnt_c;
            end
            ISSUE: begin
                spi_recv_val = 1'b1;
                spi_recv_msg = msg_q;
                spi_pkt_val  = 1'b1;
                spi_pkt_msg  = issue_cfg_q.packet_size;
                spi_cs_val   = 1'b1;
                spi_cs_msg   = issue_cfg_q.cs_addr;
                spi_freq_val = 1'b1;
                spi_freq_msg = issue_cfg_q.freq;
            end
            WAIT: begin
                resp_val[gnt_q] = spi_send_val;
                resp_msg        = spi_send_msg;
                spi_send_rdy    = resp_rdy[gnt_q];
            end
            default: begin
            end
        endcase
    end

    assign cfg_rdy = 1'b1;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: scoreboarded transactions through
// a bench-side SPI master model, plus grant-order, backpressure and reset scenarios.
module tb_spi_master_arbiter;

    localparam int NB = 34;
    localparam int NR = 4;

    typedef struct {
        int            port;
        logic [NB-1:0] msg;
        logic [6:0]    size;
        logic [0:0]    cs;
        logic [2:0]    freq;
    } txn_t;

    typedef struct {
        logic [NR-1:0] rv;
        logic [NB-1:0] msg;
    } rsp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_val, req_rdy, resp_val, resp_rdy;
    logic [NR*NB-1:0] req_msg;
    logic [NB-1:0]   resp_msg;
    logic            cfg_val, cfg_rdy;
    logic [1:0]      cfg_addr;
    logic [10:0]     cfg_msg;
    logic            spi_recv_val, spi_recv_rdy, spi_send_val, spi_send_rdy;
    logic [NB-1:0]   spi_recv_msg, spi_send_msg;
    logic            spi_pkt_val, spi_pkt_rdy, spi_cs_val, spi_cs_rdy, spi_freq_val, spi_freq_rdy;
    logic [6:0]      spi_pkt_msg;
    logic [0:0]      spi_cs_msg;
    logic [2:0]      spi_freq_msg;

    int   total = 0;
    int   bad   = 0;
    txn_t exp_q[$];
    rsp_t rsp_q[$];
    int   gq[$];

    assign spi_pkt_rdy  = spi_recv_rdy;
    assign spi_cs_rdy   = spi_recv_rdy;
    assign spi_freq_rdy = spi_recv_rdy;

    always #5 clk = ~clk;

    spi_master_arbiter #(.nreq(NR)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr), .cfg_msg(cfg_msg),
        .spi_recv_val(spi_recv_val), .spi_recv_rdy(spi_recv_rdy), .spi_recv_msg(spi_recv_msg),
        .spi_send_val(spi_send_val), .spi_send_rdy(spi_send_rdy), .spi_send_msg(spi_send_msg),
        .spi_pkt_val(spi_pkt_val), .spi_pkt_rdy(spi_pkt_rdy), .spi_pkt_msg(spi_pkt_msg),
        .spi_cs_val(spi_cs_val), .spi_cs_rdy(spi_cs_rdy), .spi_cs_msg(spi_cs_msg),
        .spi_freq_val(spi_freq_val), .spi_freq_rdy(spi_freq_rdy), .spi_freq_msg(spi_freq_msg)
    );

    function automatic txn_t mk(input int p, input logic [NB-1:0] m, input logic [6:0] s,
                                input logic [0:0] c, input logic [2:0] f);
        txn_t t;
        t.port = p; t.msg = m; t.size = s; t.cs = c; t.freq = f;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_cfg(input int port, input logic [2:0] f, input logic c, input logic [6:0] s);
        cfg_val = 1'b1; cfg_addr = 2'(port); cfg_msg = {f, c, s};
        tick();
        cfg_val = 1'b0;
    endtask

    task automatic issue_req(input int port, input logic [NB-1:0] m, output logic [NR-1:0] seen);
        int n = 0;
        req_msg[port*NB +: NB] = m;
        req_val[port] = 1'b1;
        @(negedge clk);
        while (req_rdy == '0 && n < 50) begin @(negedge clk); n++; end
        seen = req_rdy;
        if (req_rdy == '0) begin
            total++; bad++;
            $display("FAIL req_timeout port=%0d no req_rdy within 50 cycles", port);
        end
        @(posedge clk); #1;
        req_val[port] = 1'b0;
    endtask

    task automatic master_accept(output txn_t o);
        int n = 0;
        @(negedge clk);
        while (!spi_recv_val && n < 50) begin @(negedge clk); n++; end
        o = mk(-1, spi_recv_msg, spi_pkt_msg, spi_cs_msg, spi_freq_msg);
        if (!spi_recv_val) begin
            total++; bad++;
            $display("FAIL recv_timeout no spi_recv_val within 50 cycles");
        end
        spi_recv_rdy = 1'b1;
        @(posedge clk); #1;
        spi_recv_rdy = 1'b0;
    endtask

    task automatic master_respond(input logic [NB-1:0] m, output logic [NR-1:0] rv, output logic [NB-1:0] rm);
        int n = 0;
        spi_send_val = 1'b1; spi_send_msg = m;
        @(negedge clk);
        while (!spi_send_rdy && n < 50) begin @(negedge clk); n++; end
        rv = resp_val; rm = resp_msg;
        if (!spi_send_rdy) begin
            total++; bad++;
            $display("FAIL send_timeout no spi_send_rdy within 50 cycles");
        end
        @(posedge clk); #1;
        spi_send_val = 1'b0; spi_send_msg = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_val = 4'hF; resp_rdy = 4'hF; spi_send_val = 1'b1; spi_send_msg = 34'h3_FFFF_FFFF;
        @(negedge clk);
        total++;
        if ({req_rdy, resp_val, spi_recv_val, spi_pkt_val, spi_cs_val, spi_freq_val, spi_send_rdy} !== '0) begin
            bad++; $display("FAIL reset_vals got=%b want=0",
                {req_rdy, resp_val, spi_recv_val, spi_pkt_val, spi_cs_val, spi_freq_val, spi_send_rdy});
        end
        total++;
        if ({resp_msg, spi_recv_msg, spi_pkt_msg, spi_cs_msg, spi_freq_msg} !== '0) begin
            bad++; $display("FAIL reset_msgs got=%h want=0",
                {resp_msg, spi_recv_msg, spi_pkt_msg, spi_cs_msg, spi_freq_msg});
        end
        total++;
        if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_cfg_rdy got=%b want=1", cfg_rdy); end
        req_val = '0; spi_send_val = 1'b0; spi_send_msg = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [NR-1:0] seen, rv;
        logic [NB-1:0] rm;
        txn_t o, e;
        rsp_t r;
        write_cfg(1, 3'd2, 1'b0, 7'd8);
        exp_q.push_back(mk(1, 34'hA5, 7'd8, 1'b0, 3'd2));
        issue_req(1, 34'hA5, seen);
        total++;
        if (seen !== 4'b0010) begin bad++; $display("FAIL basic_grant got=%b want=0010", seen); end
        master_accept(o);
        e = exp_q.pop_front();
        total++;
        if ({o.msg, o.size, o.cs, o.freq} !== {e.msg, e.size, e.cs, e.freq}) begin
            bad++; $display("FAIL basic_issue got=%h/%0d/%0d/%0d want=%h/%0d/%0d/%0d",
                o.msg, o.size, o.cs, o.freq, e.msg, e.size, e.cs, e.freq);
        end
        rsp_q.push_back('{rv: 4'b0010, msg: 34'hA5});
        master_respond(o.msg, rv, rm);
        r = rsp_q.pop_front();
        total++;
        if ({rv, rm} !== {r.rv, r.msg}) begin
            bad++; $display("FAIL basic_resp got=%b/%h want=%b/%h", rv, rm, r.rv, r.msg);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] rv;
        logic [NB-1:0] rm;
        txn_t o, e;
        int g, n;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        for (int p = 0; p < NR; p++) req_msg[p*NB +: NB] = 34'h100 + 34'(p);
        for (int k = 0; k < 8; k++) begin
            gq.push_back(k % NR);
            exp_q.push_back(mk(k % NR, 34'h100 + 34'(k % NR), 7'd34, 1'b0, 3'd0));
        end
        req_val = 4'hF;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            @(negedge clk);
            while (req_rdy == '0 && n < 50) begin @(negedge clk); n++; end
            g = gq.pop_front();
            total++;
            if (req_rdy !== (4'b0001 << g)) begin
                bad++; $display("FAIL rr_grant k=%0d got=%b want=%0d", k, req_rdy, g);
            end
            @(posedge clk); #1;
            master_accept(o);
            e = exp_q.pop_front();
            total++;
            if ({o.msg, o.size, o.cs, o.freq} !== {e.msg, e.size, e.cs, e.freq}) begin
                bad++; $display("FAIL rr_issue k=%0d got=%h/%0d want=%h/%0d", k, o.msg, o.size, e.msg, e.size);
            end
            master_respond(e.msg ^ 34'h2_0000_0000, rv, rm);
            total++;
            if ({rv, rm} !== {4'b0001 << e.port, e.msg ^ 34'h2_0000_0000}) begin
                bad++; $display("FAIL rr_resp k=%0d got=%b/%h want port %0d", k, rv, rm, e.port);
            end
        end
        req_val = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] seen, rv;
        logic [NB-1:0] rm;
        txn_t o, e;
        exp_q.push_back(mk(2, 34'h2_DEAD_BEEF, 7'd34, 1'b0, 3'd0));
        issue_req(2, 34'h2_DEAD_BEEF, seen);
        master_accept(o);
        e = exp_q.pop_front();
        total++;
        if ({o.msg, o.size} !== {e.msg, e.size}) begin
            bad++; $display("FAIL bp_issue got=%h/%0d want=%h/%0d", o.msg, o.size, e.msg, e.size);
        end
        resp_rdy = '0; spi_send_val = 1'b1; spi_send_msg = 34'h1234;
        req_msg[0 +: NB] = 34'h77; req_val[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if ({resp_val, spi_send_rdy, req_rdy} !== {4'b0100, 1'b0, 4'b0000}) begin
                bad++; $display("FAIL bp_hold c=%0d resp_val=%b send_rdy=%b req_rdy=%b", c, resp_val, spi_send_rdy, req_rdy);
            end
        end
        @(posedge clk); #1;
        resp_rdy = '1;
        @(negedge clk);
        total++;
        if ({spi_send_rdy, resp_val, resp_msg} !== {1'b1, 4'b0100, 34'h1234}) begin
            bad++; $display("FAIL bp_release send_rdy=%b resp_val=%b msg=%h", spi_send_rdy, resp_val, resp_msg);
        end
        @(posedge clk); #1;
        spi_send_val = 1'b0;
        @(negedge clk);
        total++;
        if (req_rdy !== 4'b0001) begin bad++; $display("FAIL bp_idle got=%b want=0001", req_rdy); end
        @(posedge clk); #1;
        req_val[0] = 1'b0;
        master_accept(o);
        master_respond(34'h0, rv, rm);
    endtask

    task automatic test_cfg_race();
        logic [NR-1:0] seen, rv;
        logic [NB-1:0] rm;
        txn_t o, e;
        exp_q.push_back(mk(2, 34'h222, 7'd34, 1'b0, 3'd0));
        exp_q.push_back(mk(2, 34'h333, 7'd12, 1'b0, 3'd0));
        req_msg[2*NB +: NB] = 34'h222; req_val[2] = 1'b1;
        cfg_val = 1'b1; cfg_addr = 2'd2; cfg_msg = {3'd0, 1'b0, 7'd12};
        @(negedge clk);
        total++;
        if (req_rdy !== 4'b0100) begin bad++; $display("FAIL race_grant got=%b want=0100", req_rdy); end
        @(posedge clk); #1;
        req_val[2] = 1'b0; cfg_val = 1'b0;
        master_accept(o);
        e = exp_q.pop_front();
        total++;
        if ({o.msg, o.size} !== {e.msg, e.size}) begin
            bad++; $display("FAIL race_old_cfg got=%h/%0d want=%h/%0d", o.msg, o.size, e.msg, e.size);
        end
        master_respond(34'h0, rv, rm);
        issue_req(2, 34'h333, seen);
        master_accept(o);
        e = exp_q.pop_front();
        total++;
        if ({o.msg, o.size} !== {e.msg, e.size}) begin
            bad++; $display("FAIL race_new_cfg got=%h/%0d want=%h/%0d", o.msg, o.size, e.msg, e.size);
        end
        master_respond(34'h0, rv, rm);
    endtask

    task automatic test_recv_stall();
        logic [NR-1:0] seen, rv;
        logic [NB-1:0] rm;
        txn_t o, e;
        write_cfg(0, 3'd5, 1'b1, 7'd20);
        exp_q.push_back(mk(0, 34'h3_0F0F_0F0F, 7'd20, 1'b1, 3'd5));
        issue_req(0, 34'h3_0F0F_0F0F, seen);
        e = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({spi_recv_val, spi_pkt_val, spi_cs_val, spi_freq_val, spi_recv_msg, spi_pkt_msg, spi_cs_msg, spi_freq_msg}
                !== {4'hF, e.msg, e.size, e.cs, e.freq}) begin
                bad++; $display("FAIL stall_hold c=%0d vals=%b msg=%h pkt=%0d cs=%0d freq=%0d",
                    c, {spi_recv_val, spi_pkt_val, spi_cs_val, spi_freq_val}, spi_recv_msg, spi_pkt_msg, spi_cs_msg, spi_freq_msg);
            end
        end
        master_accept(o);
        e = exp_q.pop_front();
        total++;
        if ({o.msg, o.size, o.cs, o.freq} !== {e.msg, e.size, e.cs, e.freq}) begin
            bad++; $display("FAIL stall_accept got=%h/%0d/%0d/%0d want=%h/%0d/%0d/%0d",
                o.msg, o.size, o.cs, o.freq, e.msg, e.size, e.cs, e.freq);
        end
        master_respond(34'h0, rv, rm);
    endtask

    task automatic test_async_reset();
        logic [NR-1:0] seen, rv;
        logic [NB-1:0] rm;
        txn_t o, e;
        issue_req(1, 34'h1_1111, seen);
        master_accept(o);
        resp_rdy = '0; spi_send_val = 1'b1; spi_send_msg = 34'h55;
        @(negedge clk);
        total++;
        if (resp_val !== 4'b0010) begin bad++; $display("FAIL ar_pre got=%b want=0010", resp_val); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({req_rdy, resp_val, spi_recv_val, spi_pkt_val, spi_cs_val, spi_freq_val, spi_send_rdy,
             resp_msg, spi_recv_msg, spi_pkt_msg, spi_cs_msg, spi_freq_msg} !== '0) begin
            bad++; $display("FAIL ar_outputs resp_val=%b send_rdy=%b resp_msg=%h", resp_val, spi_send_rdy, resp_msg);
        end
        total++;
        if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL ar_cfg_rdy got=%b want=1", cfg_rdy); end
        @(posedge clk); #1;
        reset = 1'b0; spi_send_val = 1'b0; spi_send_msg = '0; resp_rdy = '1;
        for (int p = 0; p < NR; p++) req_msg[p*NB +: NB] = 34'h40 + 34'(p);
        exp_q.push_back(mk(0, 34'h40, 7'd34, 1'b0, 3'd0));
        req_val = 4'hF;
        @(negedge clk);
        total++;
        if (req_rdy !== 4'b0001) begin bad++; $display("FAIL ar_rr_ptr got=%b want=0001", req_rdy); end
        @(posedge clk); #1;
        req_val = '0;
        master_accept(o);
        e = exp_q.pop_front();
        total++;
        if ({o.msg, o.size, o.cs, o.freq} !== {e.msg, e.size, e.cs, e.freq}) begin
            bad++; $display("FAIL ar_cfg got=%h/%0d/%0d/%0d want=%h/%0d/%0d/%0d",
                o.msg, o.size, o.cs, o.freq, e.msg, e.size, e.cs, e.freq);
        end
        master_respond(34'h0, rv, rm);
    endtask

    initial begin
        reset = 1'b1; req_val = '0; req_msg = '0; resp_rdy = '1;
        cfg_val = 1'b0; cfg_addr = '0; cfg_msg = '0;
        spi_recv_rdy = 1'b0; spi_send_val = 1'b0; spi_send_msg = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_cfg_race();
        test_recv_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
